// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: op codes,
// FSM states, response flag bit positions, default width.
package alu_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV,
    OP_SLL, OP_SRL, OP_ROL, OP_ROR,
    OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_NAND, OP_XNOR, OP_GT, OP_EQ
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } seq_state_e;

  localparam int FLG_CARRY = 0;
  localparam int FLG_OVF   = 1;
  localparam int FLG_ERR   = 2;

endpackage

// File: rtl/alu_regfile.sv
// Register file: 2 async read ports, 1 write port muxing
// direct loads and ALU writeback (writeback wins). Async clear.
module alu_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  logic [DW-1:0] mem [NREG];

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

  // A load to a register other than the writeback
  // target still lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && wb_addr == AW'(i))
          mem[i] <= wb_data;
        else if (ld_en && ld_addr == AW'(i))
          mem[i] <= ld_data;
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer: accept cmd, drive external ALU, write back,
// hold response. Ports: cmd_*, ld_*, alu_*, rsp_*. Option macro:
// SEQ_DIV_ZERO_CHECK_EN (DIV by zero -> all-ones, err flag).
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  input  logic          alu_ovf,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [2:0]    rsp_flags
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] rs1_data, rs2_data;
  logic [DW-1:0] res;
  logic [2:0]    flg;
  logic          accept;
  logic          wb_en;

  // rst_n gating keeps cmd_ready low while held in reset.
  assign cmd_ready = rst_n && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign wb_en     = (state_q == ST_EXEC);

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra1     (cmd_rs1),
    .rd1     (rs1_data),
    .ra2     (cmd_rs2),
    .rd2     (rs2_data),
    .ld_en   (ld_valid),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wb_en   (wb_en),
    .wb_addr (rd_q),
    .wb_data (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    res             = alu_out;
    flg             = '0;
    flg[FLG_CARRY]  = alu_carry;
    flg[FLG_OVF]    = alu_ovf;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    if (alu_sel == 4'(OP_DIV) && alu_b == '0) begin
      res          = '1;
      flg          = '0;
      flg[FLG_ERR] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rd_q      <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else begin
      if (accept) begin
        alu_a   <= rs1_data;
        alu_b   <= rs2_data;
        alu_sel <= cmd_op;
        rd_q    <= cmd_rd;
      end
      if (wb_en) begin
        rsp_data  <= res;
        rsp_flags <= flg;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small
// behavioural ALU model on the alu_* ports.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] alu_a, alu_b;
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_out;
  logic          alu_carry, alu_ovf;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [2:0]    rsp_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DW(DW), .NREG(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_ovf   (alu_ovf),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags)
  );

  // ALU model; divide by zero returns a marker value.
  logic [DW:0] sum;
  always_comb begin
    sum       = '0;
    alu_out   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_sel)
      4'(OP_ADD): begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out   = sum[DW-1:0];
        alu_carry = sum[DW];
        alu_ovf   = (alu_a[DW-1] == alu_b[DW-1]) &&
                    (sum[DW-1] != alu_a[DW-1]);
      end
      4'(OP_SUB): begin
        sum       = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
        alu_out   = sum[DW-1:0];
        alu_carry = sum[DW];
        alu_ovf   = (alu_a[DW-1] != alu_b[DW-1]) &&
                    (sum[DW-1] != alu_a[DW-1]);
      end
      4'(OP_DIV):
        alu_out = (alu_b == '0) ? 16'hDEAD : alu_a / alu_b;
      4'(OP_EQ):
        alu_out = {15'd0, alu_a == alu_b};
      default: alu_out = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic offer(input logic [3:0] op,
                       input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: ready=%b valid=%b req 0 0",
               cmd_ready, rsp_valid);
    end
    checks++;
    if (rsp_data !== '0 || rsp_flags !== '0 ||
        alu_a !== '0 || alu_b !== '0 || alu_sel !== '0) begin
      errors++;
      $display("FAIL reset_out: d=%h f=%b a=%h b=%h s=%h req 0",
               rsp_data, rsp_flags, alu_a, alu_b, alu_sel);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rel_ready: got %b req 1", cmd_ready);
    end
  endtask

  task automatic test_add();
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    rsp_ready = 1'b1;
    offer(4'(OP_ADD), 3'd3, 3'd1, 3'd2);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || alu_a !== 16'h5 ||
        alu_b !== 16'h3 || alu_sel !== 4'(OP_ADD)) begin
      errors++;
      $display("FAIL add_exec: v=%b a=%h b=%h s=%h req 0 5 3 0",
               rsp_valid, alu_a, alu_b, alu_sel);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0008 ||
        rsp_flags !== 3'b000) begin
      errors++;
      $display("FAIL add_rsp: v=%b d=%h f=%b req 1 0008 000",
               rsp_valid, rsp_data, rsp_flags);
    end
    checks++;
    if (dut.u_regfile.mem[3] !== 16'h0008) begin
      errors++;
      $display("FAIL add_r3: got %h req 0008",
               dut.u_regfile.mem[3]);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_idle: ready=%b valid=%b req 1 0",
               cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    offer(4'(OP_SUB), 3'd5, 3'd1, 3'd2);
    tick();
    offer(4'(OP_ADD), 3'd6, 3'd3, 3'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
          rsp_data !== 16'h0002 || rsp_flags !== 3'b001) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%b r=%b d=%h f=%b req 1 0 0002 001",
                 i, rsp_valid, cmd_ready, rsp_data, rsp_flags);
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        alu_sel !== 4'(OP_SUB) ||
        dut.u_regfile.mem[6] !== 16'h0000) begin
      errors++;
      $display("FAIL bp_release: r=%b v=%b s=%h r6=%h req 1 0 1 0",
               cmd_ready, rsp_valid, alu_sel,
               dut.u_regfile.mem[6]);
    end
  endtask

  task automatic test_div_zero();
    logic [DW-1:0] exp_d;
    logic [2:0]    exp_f;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    exp_d = 16'hFFFF;
    exp_f = 3'b100;
`else
    exp_d = 16'hDEAD;
    exp_f = 3'b000;
`endif
    load(3'd2, 16'h0000);
    offer(4'(OP_DIV), 3'd4, 3'd1, 3'd2);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d ||
        rsp_flags !== exp_f) begin
      errors++;
      $display("FAIL div0_rsp: v=%b d=%h f=%b req 1 %h %b",
               rsp_valid, rsp_data, rsp_flags, exp_d, exp_f);
    end
    checks++;
    if (dut.u_regfile.mem[4] !== exp_d) begin
      errors++;
      $display("FAIL div0_r4: got %h req %h",
               dut.u_regfile.mem[4], exp_d);
    end
    tick();
  endtask

  task automatic test_wb_collision();
    load(3'd2, 16'h0003);
    load(3'd3, 16'h0000);
    offer(4'(OP_ADD), 3'd3, 3'd1, 3'd2);
    tick();
    cmd_valid = 1'b0;
    ld_valid  = 1'b1;
    ld_addr   = 3'd3;
    ld_data   = 16'h1234;
    tick();
    ld_valid  = 1'b0;
    checks++;
    if (dut.u_regfile.mem[3] !== 16'h0008) begin
      errors++;
      $display("FAIL collide_r3: got %h req 0008",
               dut.u_regfile.mem[3]);
    end
    tick();
  endtask

  task automatic test_eq_no_bypass();
    load(3'd1, 16'h00AA);
    load(3'd2, 16'h00AA);
    offer(4'(OP_EQ), 3'd1, 3'd1, 3'd2);
    ld_valid = 1'b1;
    ld_addr  = 3'd2;
    ld_data  = 16'h00AB;
    tick();
    cmd_valid = 1'b0;
    ld_valid  = 1'b0;
    checks++;
    if (alu_b !== 16'h00AA || dut.u_regfile.mem[2] !== 16'h00AB) begin
      errors++;
      $display("FAIL eq_nobypass: b=%h r2=%h req 00aa 00ab",
               alu_b, dut.u_regfile.mem[2]);
    end
    tick();
    checks++;
    if (rsp_data !== 16'h0001 || rsp_flags !== 3'b000 ||
        dut.u_regfile.mem[1] !== 16'h0001) begin
      errors++;
      $display("FAIL eq_rsp: d=%h f=%b r1=%h req 0001 000 0001",
               rsp_data, rsp_flags, dut.u_regfile.mem[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    logic any_nz;
    load(3'd7, 16'h7777);
    offer(4'(OP_ADD), 3'd7, 3'd7, 3'd7);
    tick();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    any_nz = 1'b0;
    for (int i = 0; i < 8; i++)
      if (dut.u_regfile.mem[i] !== '0) any_nz = 1'b1;
    checks++;
    if (any_nz !== 1'b0 || rsp_valid !== 1'b0 ||
        cmd_ready !== 1'b0 || alu_a !== '0) begin
      errors++;
      $display("FAIL rst_mid: nz=%b v=%b r=%b a=%h req 0 0 0 0",
               any_nz, rsp_valid, cmd_ready, alu_a);
    end
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || dut.u_regfile.mem[7] !== '0) begin
      errors++;
      $display("FAIL rst_mid_hold: v=%b r7=%h req 0 0",
               rsp_valid, dut.u_regfile.mem[7]);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_rel: ready=%b req 1", cmd_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_idle: v=%b r=%b req 0 1",
               rsp_valid, cmd_ready);
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    #2;
    test_reset();
    test_add();
    test_backpressure();
    test_div_zero();
    test_wb_collision();
    test_eq_no_bypass();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
